// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a prefetch queue.
//
// Fetches 32-bit opcodes over a 16- or 32-bit bus (BEATS = 32/BUS_W beats per
// opcode), buffers them in a DEPTH-entry queue, and dispatches them to the
// execute unit. Handles branch redirects and illegal-instruction traps.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   dat_i, ack_i          bus read data and beat acknowledge
//   adr_o, size_o, vpa_o  bus beat address, transfer size, fetch-in-progress
//   pause_i               execute unit still consuming ir_o
//   defined_i             decoder verdict on ir_o
//   redirect_i/_pc_i      taken branch/jump and its target (word address)
//   csr_mtvec_i           trap vector (word address)
//   ir_o, ir_valid_o      current instruction and its valid flag
//   cpc_o, mepc_o         address of ir_o, PC captured at last trap
//   mpie_mie_o, mie_0_o, mcause_2_o   trap strobes to the CSR unit
//
// Fetch FSM
//   state   | meaning
//   S_IDLE  | queue full, no bus activity
//   S_BEAT  | fetch beat beat_q of the opcode at npc in progress
//   S_DRAIN | flushed while a beat was in flight; wait for its ack, drop data
module fetch_queue #(
  parameter int unsigned BUS_W    = 16,
  parameter int unsigned DEPTH    = 2,
  parameter logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FF00
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [BUS_W-1:0] dat_i,
  input  logic             ack_i,
  output logic [63:0]      adr_o,
  output logic [1:0]       size_o,
  output logic             vpa_o,
  input  logic             pause_i,
  input  logic             defined_i,
  input  logic             redirect_i,
  input  logic [63:2]      redirect_pc_i,
  input  logic [63:2]      csr_mtvec_i,
  output logic [31:0]      ir_o,
  output logic             ir_valid_o,
  output logic [63:2]      cpc_o,
  output logic [63:2]      mepc_o,
  output logic             mpie_mie_o,
  output logic             mie_0_o,
  output logic             mcause_2_o
);

  localparam int unsigned BEATS = 32 / BUS_W;
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [1:0]  SIZE_CODE = (BUS_W == 16) ? 2'b10 : 2'b11;
  localparam logic [63:0] BEAT_BYTES = 64'(BUS_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic          beat_q, beat_d;
  logic [63:2]   npc_q, npc_d;
  logic [63:0]   drain_adr_q, drain_adr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic [63:2]   cpc_q, cpc_d;
  logic [63:2]   mepc_q, mepc_d;

  logic [31:0]   q_ir_q [DEPTH];
  logic [63:2]   q_pc_q [DEPTH];

  logic          trap, flush, last_beat, push, pop;
  logic [63:0]   adr_beat;
  logic [31:0]   word_full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign trap      = ir_valid_q & ~defined_i;
  assign flush     = trap | redirect_i;
  assign last_beat = (beat_q == 1'(BEATS - 1));
  // A flush kills the opcode under assembly even if its final beat acks now.
  assign push      = (state_q == S_BEAT) && ack_i && last_beat && !flush;
  assign pop       = !pause_i && !flush && (count_q != '0);
  assign adr_beat  = {npc_q, 2'b00} + (beat_q ? BEAT_BYTES : 64'd0);

  // Opcode assembly: on a 16-bit bus the low half is held until the upper
  // half arrives; the full word is formed combinationally on the last beat.
  if (BEATS == 1) begin : g_w32
    assign word_full = dat_i;
  end else begin : g_w16
    logic [15:0] lo_q;
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        lo_q <= '0;
      end else if ((state_q == S_BEAT) && ack_i && !last_beat) begin
        lo_q <= dat_i;
      end
    end
    assign word_full = {dat_i, lo_q};
  end

  // Queue, pointer, dispatch and trap bookkeeping.
  always_comb begin
    npc_d      = npc_q;
    mepc_d     = mepc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    cpc_d      = cpc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (trap) begin
      mepc_d = cpc_q;
      npc_d  = csr_mtvec_i;
    end else if (redirect_i) begin
      npc_d = redirect_pc_i;
    end else if (push) begin
      npc_d = npc_q + 62'd1;
    end

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ir_d       = NOP;
      ir_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CW'(1);
      end
      if (!pause_i) begin
        if (pop) begin
          ir_d       = q_ir_q[rd_ptr_q];
          cpc_d      = q_pc_q[rd_ptr_q];
          ir_valid_d = 1'b1;
        end else begin
          ir_d       = NOP;
          ir_valid_d = 1'b0;
        end
      end
    end
  end

  // Fetch FSM next state. The slot under assembly is reserved, so a new
  // opcode is only started while the committed count is below DEPTH.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    drain_adr_d = drain_adr_q;
    case (state_q)
      S_IDLE: begin
        beat_d = 1'b0;
        if (flush || (count_q < CW'(DEPTH))) state_d = S_BEAT;
      end
      S_BEAT: begin
        if (flush) begin
          beat_d      = 1'b0;
          drain_adr_d = adr_beat;
          state_d     = ack_i ? S_BEAT : S_DRAIN;
        end else if (ack_i) begin
          if (last_beat) begin
            beat_d  = 1'b0;
            state_d = (count_d < CW'(DEPTH)) ? S_BEAT : S_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        beat_d = 1'b0;
        if (ack_i) state_d = S_BEAT;
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = 1'b0;
      end
    endcase
  end

  // Reset goes straight to BEAT(0): the queue is empty, so the first fetch
  // at RESET_PC can start in the first cycle after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_BEAT;
      beat_q      <= 1'b0;
      npc_q       <= RESET_PC[63:2];
      drain_adr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ir_q        <= NOP;
      ir_valid_q  <= 1'b0;
      cpc_q       <= '0;
      mepc_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      npc_q       <= npc_d;
      drain_adr_q <= drain_adr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      cpc_q       <= cpc_d;
      mepc_q      <= mepc_d;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_ir_q[wr_ptr_q] <= word_full;
      q_pc_q[wr_ptr_q] <= npc_q;
    end
  end

  assign vpa_o      = !reset_i && ((state_q == S_BEAT) || (state_q == S_DRAIN));
  assign adr_o      = !vpa_o ? 64'd0 : ((state_q == S_DRAIN) ? drain_adr_q : adr_beat);
  assign size_o     = vpa_o ? SIZE_CODE : 2'b00;
  assign mpie_mie_o = trap & ~reset_i;
  assign mie_0_o    = trap & ~reset_i;
  assign mcause_2_o = trap & ~reset_i;
  assign ir_o       = ir_q;
  assign ir_valid_o = ir_valid_q;
  assign cpc_o      = cpc_q;
  assign mepc_o     = mepc_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam logic [63:2] RPC   = 62'h3FFF_FFFF_FFFF_FFC0;
  localparam logic [63:0] RADR  = 64'hFFFF_FFFF_FFFF_FF00;
  localparam logic [63:2] MTVEC = 62'h1DDD_DDDD_DDDD_DDDD;

  typedef struct packed {
    logic [63:2] pc;
    logic [31:0] ir;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ack, pause, defined, redirect;
  logic [63:2] redirect_pc, mtvec;

  logic [15:0] dat16;
  logic [63:0] adr16;
  logic [1:0]  size16;
  logic        vpa16, valid16, s1_16, s2_16, s3_16;
  logic [31:0] ir16;
  logic [63:2] cpc16, mepc16;

  logic [31:0] dat32;
  logic [63:0] adr32;
  logic [1:0]  size32;
  logic        vpa32, valid32, s1_32, s2_32, s3_32;
  logic [31:0] ir32;
  logic [63:2] cpc32, mepc32;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Bus memory images: each halfword/word is a fixed function of its address.
  function automatic logic [15:0] half16(input logic [63:0] a);
    return (a[1] ? 16'hBBBB : 16'hAAAA) ^ {a[15:2], 2'b00} ^ 16'hFF00;
  endfunction
  function automatic logic [31:0] word16(input logic [63:2] pc);
    logic [63:0] a;
    a = {pc, 2'b00};
    return {half16(a + 64'd2), half16(a)};
  endfunction
  function automatic logic [31:0] word32(input logic [63:0] a);
    return 32'h1234_5678 ^ a[31:0] ^ 32'hFFFF_FF00;
  endfunction

  assign dat16 = half16(adr16);
  assign dat32 = word32(adr32);

  fetch_queue #(.BUS_W(16), .DEPTH(2)) u16 (
    .clk_i(clk), .reset_i(rst), .dat_i(dat16), .ack_i(ack),
    .adr_o(adr16), .size_o(size16), .vpa_o(vpa16),
    .pause_i(pause), .defined_i(defined), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .csr_mtvec_i(mtvec),
    .ir_o(ir16), .ir_valid_o(valid16), .cpc_o(cpc16), .mepc_o(mepc16),
    .mpie_mie_o(s1_16), .mie_0_o(s2_16), .mcause_2_o(s3_16));

  fetch_queue #(.BUS_W(32), .DEPTH(2)) u32 (
    .clk_i(clk), .reset_i(rst), .dat_i(dat32), .ack_i(ack),
    .adr_o(adr32), .size_o(size32), .vpa_o(vpa32),
    .pause_i(pause), .defined_i(defined), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .csr_mtvec_i(mtvec),
    .ir_o(ir32), .ir_valid_o(valid32), .cpc_o(cpc32), .mepc_o(mepc32),
    .mpie_mie_o(s1_32), .mie_0_o(s2_32), .mcause_2_o(s3_32));

  // Holds reset for n edges; returns #1 into cycle 0 after release.
  task automatic do_reset(input int n, input logic ack_v, input logic pause_v);
    @(negedge clk);
    rst = 1'b1; ack = ack_v; pause = pause_v; defined = 1'b1; redirect = 1'b0;
    sb.delete();
    repeat (n) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Pops and compares one expected entry per dispatch edge of the 16-bit DUT.
  task automatic run_sb(input int budget);
    int   c;
    logic pp;
    exp_t e;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      pp = pause;
      @(negedge clk); #1;
      c++;
      if (!pp && valid16) begin
        e = sb.pop_front();
        n_tests++;
        if (cpc16 !== e.pc) begin n_fail++; $display("FAIL sb_cpc: got %h expected %h", cpc16, e.pc); end
        n_tests++;
        if (ir16 !== e.ir) begin n_fail++; $display("FAIL sb_ir: got %h expected %h", ir16, e.ir); end
      end
    end
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL sb_timeout: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ack = 1'b1; pause = 1'b0; defined = 1'b1; redirect = 1'b0;
    #1;
    n_tests++;
    if ({vpa16, size16, adr16} !== 67'd0) begin n_fail++; $display("FAIL reset_bus: got vpa %b size %b adr %h expected 0", vpa16, size16, adr16); end
    n_tests++;
    if ({s1_16, s2_16, s3_16} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000", {s1_16, s2_16, s3_16}); end
    @(negedge clk); #1;
    n_tests++;
    if (ir16 !== 32'h13 || valid16 !== 1'b0) begin n_fail++; $display("FAIL reset_ir: got %h/%b expected 00000013/0", ir16, valid16); end
    n_tests++;
    if (cpc16 !== 62'd0 || mepc16 !== 62'd0) begin n_fail++; $display("FAIL reset_pc: got cpc %h mepc %h expected 0", cpc16, mepc16); end
    n_tests++;
    if (vpa16 !== 1'b0 || vpa32 !== 1'b0) begin n_fail++; $display("FAIL reset_vpa: got %b %b expected 0 0", vpa16, vpa32); end
  endtask

  task automatic test_reset_fetch();
    do_reset(2, 1'b1, 1'b0);
    n_tests++;
    if (adr16 !== RADR || size16 !== 2'b10 || vpa16 !== 1'b1) begin n_fail++; $display("FAIL rf_beat0: got %h %b %b expected %h 10 1", adr16, size16, vpa16, RADR); end
    @(negedge clk); #1;
    n_tests++;
    if (adr16 !== RADR + 64'd2 || size16 !== 2'b10) begin n_fail++; $display("FAIL rf_beat1: got %h %b expected %h 10", adr16, size16, RADR + 64'd2); end
    @(negedge clk); #1;
    n_tests++;
    if (valid16 !== 1'b0) begin n_fail++; $display("FAIL rf_early_valid: got %b expected 0", valid16); end
    @(negedge clk); #1;
    n_tests++;
    if (valid16 !== 1'b1 || ir16 !== 32'hBBBB_AAAA || cpc16 !== RPC) begin n_fail++; $display("FAIL rf_first: got %b %h %h expected 1 bbbbaaaa %h", valid16, ir16, cpc16, RPC); end
    for (int i = 1; i <= 3; i++) sb.push_back('{pc: RPC + 62'(i), ir: word16(RPC + 62'(i))});
    run_sb(30);
  endtask

  task automatic test_bus32();
    do_reset(1, 1'b1, 1'b0);
    n_tests++;
    if (adr32 !== RADR || size32 !== 2'b11 || vpa32 !== 1'b1) begin n_fail++; $display("FAIL b32_beat: got %h %b %b expected %h 11 1", adr32, size32, vpa32, RADR); end
    @(negedge clk); #1;
    n_tests++;
    if (adr32 !== RADR + 64'd4 || valid32 !== 1'b0) begin n_fail++; $display("FAIL b32_c1: got %h %b expected %h 0", adr32, valid32, RADR + 64'd4); end
    @(negedge clk); #1;
    n_tests++;
    if (valid32 !== 1'b1 || ir32 !== 32'h1234_5678 || cpc32 !== RPC) begin n_fail++; $display("FAIL b32_first: got %b %h %h expected 1 12345678 %h", valid32, ir32, cpc32, RPC); end
    @(negedge clk); #1;
    n_tests++;
    if (ir32 !== 32'h1234_567C || cpc32 !== RPC + 62'd1) begin n_fail++; $display("FAIL b32_second: got %h %h expected 1234567c %h", ir32, cpc32, RPC + 62'd1); end
  endtask

  task automatic test_queue_full();
    int   beats;
    logic hit;
    do_reset(1, 1'b1, 1'b1);
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      if (vpa16 && ack) beats++;
      @(negedge clk); #1;
    end
    n_tests++;
    if (beats != 4 || vpa16 !== 1'b0) begin n_fail++; $display("FAIL qf_fill: got beats %0d vpa %b expected 4 0", beats, vpa16); end
    pause = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (valid16 !== 1'b1 || cpc16 !== RPC || ir16 !== word16(RPC)) begin n_fail++; $display("FAIL qf_pop0: got %b %h %h expected 1 %h %h", valid16, cpc16, ir16, RPC, word16(RPC)); end
    @(negedge clk); #1;
    n_tests++;
    if (valid16 !== 1'b1 || cpc16 !== RPC + 62'd1 || ir16 !== word16(RPC + 62'd1)) begin n_fail++; $display("FAIL qf_pop1: got %b %h %h expected 1 %h", valid16, cpc16, ir16, RPC + 62'd1); end
    pause = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk); #1;
      if (vpa16 === 1'b0) hit = 1'b1;
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL qf_refill_timeout: vpa got 1 expected 0"); end
    redirect = 1'b1; redirect_pc = 62'h800;
    #1;
    n_tests++;
    if (vpa16 !== 1'b0) begin n_fail++; $display("FAIL idle_redirect_vpa: got %b expected 0", vpa16); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_tests++;
    if (vpa16 !== 1'b1 || adr16 !== 64'h2000 || valid16 !== 1'b0) begin n_fail++; $display("FAIL idle_redirect_adr: got %b %h %b expected 1 2000 0", vpa16, adr16, valid16); end
    pause = 1'b0;
    sb.push_back('{pc: 62'h800, ir: word16(62'h800)});
    sb.push_back('{pc: 62'h801, ir: word16(62'h801)});
    run_sb(30);
  endtask

  task automatic test_trap();
    logic hit;
    mtvec = MTVEC;
    do_reset(1, 1'b1, 1'b0);
    hit = valid16;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk); #1;
      if (valid16 === 1'b1) hit = 1'b1;
    end
    n_tests++;
    if (!hit || cpc16 !== RPC) begin n_fail++; $display("FAIL trap_setup: got valid %b cpc %h expected 1 %h", valid16, cpc16, RPC); end
    defined = 1'b0;
    #1;
    n_tests++;
    if ({s1_16, s2_16, s3_16} !== 3'b111) begin n_fail++; $display("FAIL trap_strobes: got %b expected 111", {s1_16, s2_16, s3_16}); end
    @(negedge clk);
    defined = 1'b1;
    #1;
    n_tests++;
    if ({s1_16, s2_16, s3_16} !== 3'b000) begin n_fail++; $display("FAIL trap_strobe_len: got %b expected 000", {s1_16, s2_16, s3_16}); end
    n_tests++;
    if (mepc16 !== RPC) begin n_fail++; $display("FAIL trap_mepc: got %h expected %h", mepc16, RPC); end
    n_tests++;
    if (ir16 !== 32'h13 || valid16 !== 1'b0) begin n_fail++; $display("FAIL trap_nop: got %h %b expected 00000013 0", ir16, valid16); end
    n_tests++;
    if (adr16 !== 64'h7777_7777_7777_7774) begin n_fail++; $display("FAIL trap_adr: got %h expected 7777777777777774", adr16); end
    sb.push_back('{pc: MTVEC, ir: word16(MTVEC)});
    run_sb(30);
  endtask

  task automatic test_redirect_mid_beat();
    do_reset(1, 1'b0, 1'b0);
    redirect = 1'b1; redirect_pc = 62'h400;
    #1;
    n_tests++;
    if (adr16 !== RADR) begin n_fail++; $display("FAIL rd_c0: got %h expected %h", adr16, RADR); end
    @(negedge clk);
    redirect = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) ack = 1'b1;
      #1;
      n_tests++;
      if (adr16 !== RADR || vpa16 !== 1'b1 || size16 !== 2'b10) begin n_fail++; $display("FAIL rd_hold c%0d: got %h %b %b expected %h 1 10", c, adr16, vpa16, size16, RADR); end
      @(negedge clk);
    end
    #1;
    n_tests++;
    if (adr16 !== 64'h1000) begin n_fail++; $display("FAIL rd_new0: got %h expected 1000", adr16); end
    @(negedge clk); #1;
    n_tests++;
    if (adr16 !== 64'h1002) begin n_fail++; $display("FAIL rd_new1: got %h expected 1002", adr16); end
    sb.push_back('{pc: 62'h400, ir: word16(62'h400)});
    run_sb(30);
  endtask

  task automatic test_reset_mid_fetch();
    do_reset(1, 1'b1, 1'b0);
    @(negedge clk);
    ack = 1'b0;
    #1;
    n_tests++;
    if (adr16 !== RADR + 64'd2) begin n_fail++; $display("FAIL rm_beat1: got %h expected %h", adr16, RADR + 64'd2); end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({vpa16, size16, adr16} !== 67'd0) begin n_fail++; $display("FAIL rm_bus_idle: got %b %b %h expected 0", vpa16, size16, adr16); end
    @(negedge clk);
    rst = 1'b0; ack = 1'b1;
    #1;
    n_tests++;
    if (ir16 !== 32'h13 || valid16 !== 1'b0 || adr16 !== RADR) begin n_fail++; $display("FAIL rm_restart: got %h %b %h expected 00000013 0 %h", ir16, valid16, adr16, RADR); end
    sb.push_back('{pc: RPC, ir: word16(RPC)});
    run_sb(30);
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; pause = 1'b0; defined = 1'b1; redirect = 1'b0;
    redirect_pc = '0; mtvec = MTVEC;
    test_reset();
    test_reset_fetch();
    test_bus32();
    test_queue_full();
    test_trap();
    test_redirect_mid_beat();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
